// File: rtl/adc_pipe_encoder_param.sv
// ----------------------------------------------------------------------------
// adc_pipe_encoder_param
// Digital back-end for an N_STAGES x 1.5-bit pipelined ADC (the last stage is
// the 3-level flash). Each stage's one-hot decision is decoded to a digit and
// an invalid-code flag. Both travel down a per-stage delay line so that all
// stages line up on the same analog sample. The aligned digits are then
// combined with the redundant-digit correction sum. The block also provides
// a clock enable, pipeline-fill tracking and a saturating invalid-sample
// counter.
// ----------------------------------------------------------------------------
module adc_pipe_encoder_param #(
    parameter int N_STAGES  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic [3*N_STAGES-1:0] d_i,
    output logic [N_STAGES:0]     d_o,
    output logic                  valid_o,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    localparam int OUT_W  = N_STAGES + 1;
    // The fill counter must be able to hold N_STAGES+1.
    localparam int FILL_W = $clog2(N_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N_STAGES + 1);

    // Decode one {high,mid,low} stage decision into {err, digit[1:0]}.
    // An illegal pattern is replaced by the mid digit and flagged.
    function automatic logic [2:0] decode_digit(input logic [2:0] code);
        logic [2:0] res;
        case (code)
            3'b100:  res = 3'b010;
            3'b010:  res = 3'b001;
            3'b001:  res = 3'b000;
            default: res = 3'b101;
        endcase
        return res;
    endfunction

    logic [1:0]          aligned_dig_s [N_STAGES];
    logic [N_STAGES-1:0] aligned_err_s;

    // Stage s (0-based) resolves its part of a sample s cycles after stage 0.
    // It therefore needs N_STAGES-s registers to meet the other stages at the
    // end of its delay line.
    for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
        localparam int DEPTH = N_STAGES - s;

        logic [2:0] dec_s;
        logic [1:0] dig_q [DEPTH];
        logic       err_q [DEPTH];

        assign dec_s = decode_digit(d_i[3*s +: 3]);

        // Delay line for this stage's digit and error flag; advances only when enabled.
        always_ff @(posedge clock_i) begin
            if (!reset_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    dig_q[i] <= 2'b00;
                    err_q[i] <= 1'b0;
                end
            end else if (en_i) begin
                dig_q[0] <= dec_s[1:0];
                err_q[0] <= dec_s[2];
                for (int i = 1; i < DEPTH; i++) begin
                    dig_q[i] <= dig_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    dig_q[i] <= dig_q[i];
                    err_q[i] <= err_q[i];
                end
            end
        end

        assign aligned_dig_s[s] = dig_q[DEPTH-1];
        assign aligned_err_s[s] = err_q[DEPTH-1];
    end

    logic [OUT_W-1:0]     sum_s;
    logic                 any_err_s;

    // Redundant-digit correction: stage s (0-based) carries weight 2^(N_STAGES-1-s).
    // The maximum is 2^(N_STAGES+1)-2, so the sum never overflows OUT_W bits.
    always_comb begin
        sum_s = '0;
        for (int s = 0; s < N_STAGES; s++) begin
            sum_s = sum_s + (OUT_W'(aligned_dig_s[s]) << (N_STAGES - 1 - s));
        end
        any_err_s = |aligned_err_s;
    end

    logic [OUT_W-1:0]     d_q;
    logic                 err_q;
    logic                 valid_q;
    logic                 valid_d;
    logic [FILL_W-1:0]    fill_q;
    logic [FILL_W-1:0]    fill_d;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic [ERR_CNT_W-1:0] cnt_d;

    // Next-state for fill tracking, valid and the saturating error counter.
    always_comb begin
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (en_i) begin
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end else begin
                fill_d = fill_q;
            end
            valid_d = (fill_d == FILL_FULL);
            if (any_err_s && (cnt_q != {ERR_CNT_W{1'b1}})) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            fill_d  = fill_q;
            cnt_d   = cnt_q;
            valid_d = 1'b0;
        end
    end

    // Output and bookkeeping registers; d_o/err_o hold while the enable is low.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            d_q     <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            if (en_i) begin
                d_q   <= sum_s;
                err_q <= any_err_s;
            end else begin
                d_q   <= d_q;
                err_q <= err_q;
            end
        end
    end

    assign d_o       = d_q;
    assign err_o     = err_q;
    assign valid_o   = valid_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_adc_pipe_encoder_param.sv
// ----------------------------------------------------------------------------
// Bench for adc_pipe_encoder_param.
// Instance A: N_STAGES=3, ERR_CNT_W=8. Instance B shares A's inputs and has
// ERR_CNT_W=2 (saturation). Instance C: N_STAGES=5 with held stage codes.
// Each new sample pushes its expected {err, code} to a queue when its stage-1
// code is driven; the entry is popped when the model says the sample is due.
// ----------------------------------------------------------------------------
module tb_adc_pipe_encoder_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic [8:0]  d_a;
    logic [3:0]  do_a;
    logic        va, ea;
    logic [7:0]  ca;
    logic [3:0]  do_b;
    logic        vb, eb;
    logic [1:0]  cb;
    logic        en_c;
    logic [14:0] d_c;
    logic [5:0]  do_c;
    logic        vc, ec;
    logic [7:0]  cc;

    adc_pipe_encoder_param #(.N_STAGES(3), .ERR_CNT_W(8)) u_a (
        .clock_i(clk), .reset_i(rst_n), .en_i(en), .d_i(d_a),
        .d_o(do_a), .valid_o(va), .err_o(ea), .err_cnt_o(ca));

    adc_pipe_encoder_param #(.N_STAGES(3), .ERR_CNT_W(2)) u_b (
        .clock_i(clk), .reset_i(rst_n), .en_i(en), .d_i(d_a),
        .d_o(do_b), .valid_o(vb), .err_o(eb), .err_cnt_o(cb));

    adc_pipe_encoder_param #(.N_STAGES(5), .ERR_CNT_W(8)) u_c (
        .clock_i(clk), .reset_i(rst_n), .en_i(en_c), .d_i(d_c),
        .d_o(do_c), .valid_o(vc), .err_o(ec), .err_cnt_o(cc));

    int vectors = 0;
    int miscompares = 0;

    // Sample model state: hist[0] is the newest sample, stored as {c3,c2,c1}.
    logic [8:0] hist [3];
    logic [4:0] expq [$];
    int         fill;
    logic [3:0] exp_d;
    logic       exp_err;
    int         exp_ca;
    int         exp_cb;

    function automatic int digit_of(input logic [2:0] c);
        if (c == 3'b100) return 2;
        else if (c == 3'b010) return 1;
        else if (c == 3'b001) return 0;
        else return 1;
    endfunction

    function automatic bit bad(input logic [2:0] c);
        return !(c == 3'b100 || c == 3'b010 || c == 3'b001);
    endfunction

    function automatic logic [4:0] expect_of(input logic [8:0] s);
        int   v;
        logic e;
        v = digit_of(s[2:0]) * 4 + digit_of(s[5:3]) * 2 + digit_of(s[8:6]);
        e = bad(s[2:0]) | bad(s[5:3]) | bad(s[8:6]);
        return {e, 4'(v)};
    endfunction

    function automatic logic [8:0] rnd_sample();
        logic [2:0] cs [3];
        logic [8:0] s;
        cs = '{3'b001, 3'b010, 3'b100};
        s = {cs[$urandom_range(0, 2)], cs[$urandom_range(0, 2)], cs[$urandom_range(0, 2)]};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic restart_model();
        hist = '{default: 9'b001001001};
        expq.delete();
        fill    = 0;
        exp_d   = 4'd0;
        exp_err = 1'b0;
        exp_ca  = 0;
        exp_cb  = 0;
    endtask

    task automatic check_a(input string where);
        chk({where, "/valid"}, {31'd0, va}, {31'd0, (en && fill == 4)});
        chk({where, "/d"}, {28'd0, do_a}, {28'd0, exp_d});
        chk({where, "/err"}, {31'd0, ea}, {31'd0, exp_err});
        chk({where, "/cnt8"}, {24'd0, ca}, exp_ca);
        chk({where, "/cnt2"}, {30'd0, cb}, exp_cb);
    endtask

    // One clock step. When enabled, sample s enters as stage 1 and older samples
    // move to stages 2 and 3. When disabled, random inputs must be ignored.
    task automatic step(input logic e, input logic [8:0] s, input string where);
        logic [4:0] item;
        if (e) begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = s;
            d_a = {hist[2][8:6], hist[1][5:3], hist[0][2:0]};
            expq.push_back(expect_of(s));
        end else begin
            d_a = 9'($urandom);
        end
        en = e;
        @(posedge clk);
        #1;
        if (e) begin
            if (fill < 4) fill++;
            if (fill == 4) begin
                if (expq.size() == 0) begin
                    chk({where, "/queue_empty"}, 32'd1, 32'd0);
                end else begin
                    item    = expq.pop_front();
                    exp_d   = item[3:0];
                    exp_err = item[4];
                    if (exp_err) begin
                        exp_ca = (exp_ca < 255) ? exp_ca + 1 : 255;
                        exp_cb = (exp_cb < 3) ? exp_cb + 1 : 3;
                    end
                end
            end
        end
        check_a(where);
    endtask

    task automatic reset_edge(input string where);
        rst_n = 1'b0;
        en    = 1'b1;
        d_a   = 9'($urandom);
        @(posedge clk);
        #1;
        restart_model();
        rst_n = 1'b1;
        chk({where, "/valid"}, {31'd0, va}, 32'd0);
        chk({where, "/d"}, {28'd0, do_a}, 32'd0);
        chk({where, "/err"}, {31'd0, ea}, 32'd0);
        chk({where, "/cnt8"}, {24'd0, ca}, 32'd0);
        chk({where, "/cnt2"}, {30'd0, cb}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        en_c  = 1'b1;
        d_a   = 9'b001001001;
        d_c   = {5{3'b100}};
        restart_model();

        // Power-on reset: everything clears, including the N=5 instance.
        reset_edge("por");
        chk("c_rst/d", {26'd0, do_c}, 32'd0);
        chk("c_rst/valid", {31'd0, vc}, 32'd0);

        // Held aligned sample d1=100 d2=010 d3=001 -> 10; valid from 4th edge.
        for (int i = 0; i < 6; i++) step(1'b1, {3'b001, 3'b010, 3'b100}, "hold10");

        // N=5: six enabled edges done with all stages at 100 -> 62.
        chk("c_all100/valid", {31'd0, vc}, 32'd1);
        chk("c_all100/d", {26'd0, do_c}, 32'd62);
        chk("c_all100/err", {31'd0, ec}, 32'd0);
        d_c = {{4{3'b001}}, 3'b010};

        // Extremes: all-low then all-high samples -> 0 and 14.
        step(1'b1, 9'b001001001, "zero");
        step(1'b1, 9'b001001001, "zero");
        step(1'b1, 9'b100100100, "full");
        step(1'b1, 9'b100100100, "full");

        // Ramp of random valid samples; each must appear 3 enabled edges later.
        for (int i = 0; i < 10; i++) step(1'b1, rnd_sample(), "ramp");

        // N=5: stage 1 at 010, the others at 001 -> 16.
        chk("c_mid/valid", {31'd0, vc}, 32'd1);
        chk("c_mid/d", {26'd0, do_c}, 32'd16);
        chk("c_mid/cnt", {24'd0, cc}, 32'd0);

        // Invalid stage-2 code -> 12 with err; then three invalid stages -> 7, one count.
        step(1'b1, {3'b100, 3'b011, 3'b100}, "inv1");
        step(1'b1, 9'b001010100, "clean");
        step(1'b1, {3'b000, 3'b011, 3'b111}, "inv3");
        for (int i = 0; i < 4; i++) step(1'b1, rnd_sample(), "flush");

        // Enable low for 4 cycles mid-stream: outputs frozen, valid low, nothing lost.
        for (int i = 0; i < 3; i++) step(1'b1, rnd_sample(), "pre_en");
        for (int i = 0; i < 4; i++) step(1'b0, 9'b0, "en_off");
        for (int i = 0; i < 5; i++) step(1'b1, rnd_sample(), "post_en");

        // Mid-stream reset: in-flight samples dropped, refill takes 4 enabled edges.
        reset_edge("mid_rst");
        for (int i = 0; i < 5; i++) step(1'b1, rnd_sample(), "refill");

        // Five consecutive erroneous samples: the 2-bit counter goes 1,2,3,3,3.
        step(1'b1, {3'b001, 3'b110, 3'b100}, "burst");
        step(1'b1, {3'b101, 3'b010, 3'b001}, "burst");
        step(1'b1, {3'b001, 3'b010, 3'b000}, "burst");
        step(1'b1, {3'b111, 3'b111, 3'b111}, "burst");
        step(1'b1, {3'b100, 3'b011, 3'b010}, "burst");
        for (int i = 0; i < 4; i++) step(1'b1, rnd_sample(), "tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
